// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong game-sequencing controller.
//   state_e      : master FSM state encoding (also exported on game_state)
//   TXT_*        : bit positions inside text_en {score, logo, rule, over}
//   WINNER_*     : winner output codes
//   bcd_inc      : two-digit saturating BCD increment
package pong_pkg;

  typedef enum logic [1:0] {
    NEWGAME = 2'd0,
    PLAY    = 2'd1,
    NEWBALL = 2'd2,
    OVER    = 2'd3
  } state_e;

  localparam int TXT_SCORE = 3;
  localparam int TXT_LOGO  = 2;
  localparam int TXT_RULE  = 1;
  localparam int TXT_OVER  = 0;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;
  localparam logic [1:0] WINNER_BOTH = 2'b11;

  // {tens, ones} + 1 in BCD; 99 holds at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = v[7:4];
    ones = v[3:0];
    if (tens == 4'd9 && ones == 4'd9) return v;
    else if (ones == 4'd9)            return {tens + 4'd1, 4'd0};
    else                              return {tens, ones + 4'd1};
  endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit saturating BCD score counter.
//   clk, reset : system clock, synchronous active-high reset
//   clr        : synchronous clear to 00 (wins over inc)
//   inc        : add one point
//   ones, tens : registered BCD digits, each always 0..9
module bcd_score_counter
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] ones,
  output logic [3:0] tens
);

  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    if (clr) begin
      ones_d = 4'd0;
      tens_d = 4'd0;
    end else if (inc) begin
      {tens_d, ones_d} = bcd_inc({tens_q, ones_q});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ones_q <= 4'd0;
      tens_q <= 4'd0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  assign ones = ones_q;
  assign tens = tens_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-sequencing controller: master game FSM, both BCD scores,
// overlay region enables, graphics freeze and winner latch.
//   clk, reset     : system clock, synchronous active-high reset
//   refresh_tick   : one pulse per frame, paces the NEWBALL/OVER timer
//   btn_any        : any paddle button held (starts game / serves)
//   p1_miss/p2_miss: ball passed left/right paddle (point to the other side)
//   dig0..dig3     : P1 ones/tens, P2 ones/tens (BCD)
//   text_en        : {score, logo, rule, over} overlay enables
//   gra_still      : freeze ball and paddles at serve positions
//   winner         : 01 P1, 10 P2, 11 both, 00 none (valid in OVER)
//   game_state     : current state encoding
//
// state   | meaning
// NEWGAME | title screen, waits for a button
// PLAY    | rally in progress, scoring on misses
// NEWBALL | pause between rallies, serve after timer expiry + button
// OVER    | game-over screen for WAIT_FRAMES frames
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 11,
  parameter int WAIT_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic       btn_any,
  input  logic       p1_miss,
  input  logic       p2_miss,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic [3:0] text_en,
  output logic       gra_still,
  output logic [1:0] winner,
  output logic [1:0] game_state
);

  localparam int              TW         = $clog2(WAIT_FRAMES + 1);
  localparam logic [TW-1:0]   TIMER_INIT = TW'(WAIT_FRAMES);
  localparam logic [7:0]      WIN_BCD    = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      text_en_q, text_en_d;
  logic            gra_still_q, gra_still_d;
  logic [1:0]      winner_q, winner_d;

  logic            p1_inc, p2_inc, score_clr;
  logic [7:0]      p1_score, p2_score, p1_next, p2_next;
  logic            p1_win, p2_win;

  bcd_score_counter u_p1_score (
    .clk   (clk),
    .reset (reset),
    .clr   (score_clr),
    .inc   (p1_inc),
    .ones  (dig0),
    .tens  (dig1)
  );

  bcd_score_counter u_p2_score (
    .clk   (clk),
    .reset (reset),
    .clr   (score_clr),
    .inc   (p2_inc),
    .ones  (dig2),
    .tens  (dig3)
  );

  // A miss credits the opposite player; the win test looks at the
  // post-increment score so the game ends on the scoring cycle.
  always_comb begin
    p1_inc   = (state_q == PLAY) && p2_miss;
    p2_inc   = (state_q == PLAY) && p1_miss;
    p1_score = {dig1, dig0};
    p2_score = {dig3, dig2};
    p1_next  = p1_inc ? bcd_inc(p1_score) : p1_score;
    p2_next  = p2_inc ? bcd_inc(p2_score) : p2_score;
    p1_win   = (p1_next == WIN_BCD);
    p2_win   = (p2_next == WIN_BCD);
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    winner_d  = winner_q;
    score_clr = 1'b0;
    case (state_q)
      NEWGAME: begin
        if (btn_any) state_d = PLAY;
      end
      PLAY: begin
        if (p1_inc || p2_inc) begin
          timer_d = TIMER_INIT;
          if (p1_win || p2_win) begin
            state_d  = OVER;
            winner_d = {p2_win, p1_win};
          end else begin
            state_d = NEWBALL;
          end
        end
      end
      NEWBALL: begin
        if (timer_q == '0) begin
          if (btn_any) state_d = PLAY;
        end else if (refresh_tick) begin
          timer_d = timer_q - TW'(1);
        end
      end
      OVER: begin
        if (timer_q == '0) begin
          state_d   = NEWGAME;
          winner_d  = WINNER_NONE;
          score_clr = 1'b1;
        end else if (refresh_tick) begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = NEWGAME;
    endcase

    // Decode from the next state so outputs line up with game_state.
    text_en_d   = 4'b0000;
    gra_still_d = 1'b1;
    case (state_d)
      NEWGAME: begin
        text_en_d[TXT_LOGO]  = 1'b1;
        text_en_d[TXT_RULE]  = 1'b1;
        text_en_d[TXT_SCORE] = 1'b1;
      end
      PLAY: begin
        text_en_d[TXT_SCORE] = 1'b1;
        gra_still_d          = 1'b0;
      end
      NEWBALL: begin
        text_en_d[TXT_SCORE] = 1'b1;
      end
      default: begin
        text_en_d[TXT_SCORE] = 1'b1;
        text_en_d[TXT_OVER]  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= NEWGAME;
      timer_q     <= TIMER_INIT;
      text_en_q   <= 4'b1110;
      gra_still_q <= 1'b1;
      winner_q    <= WINNER_NONE;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      text_en_q   <= text_en_d;
      gra_still_q <= gra_still_d;
      winner_q    <= winner_d;
    end
  end

  assign text_en    = text_en_q;
  assign gra_still  = gra_still_q;
  assign winner     = winner_q;
  assign game_state = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       refresh_tick = 1'b0;
  logic       btn_any = 1'b0;
  logic       p1_miss = 1'b0;
  logic       p2_miss = 1'b0;
  logic [3:0] dig0, dig1, dig2, dig3, text_en;
  logic       gra_still;
  logic [1:0] winner, game_state;

  int errors = 0;
  int checks = 0;

  pong_game_ctrl #(.WIN_SCORE(11), .WAIT_FRAMES(120)) dut (
    .clk          (clk),
    .reset        (reset),
    .refresh_tick (refresh_tick),
    .btn_any      (btn_any),
    .p1_miss      (p1_miss),
    .p2_miss      (p2_miss),
    .dig0         (dig0),
    .dig1         (dig1),
    .dig2         (dig2),
    .dig3         (dig3),
    .text_en      (text_en),
    .gra_still    (gra_still),
    .winner       (winner),
    .game_state   (game_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic miss(input logic a, input logic b);
    p1_miss = a;
    p2_miss = b;
    step();
    p1_miss = 1'b0;
    p2_miss = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      refresh_tick = 1'b1;
      step();
      refresh_tick = 1'b0;
    end
  endtask

  // From NEWBALL: hold the button through the full wait, then serve.
  task automatic serve();
    int n;
    btn_any = 1'b1;
    ticks(120);
    n = 0;
    while (game_state != 2'd1 && n < 4) begin
      step();
      n++;
    end
    btn_any = 1'b0;
    check("serve_state", {6'd0, game_state}, 8'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, {6'd0, game_state}, 8'd0);
    check({tag, "_p1"}, {dig1, dig0}, 8'h00);
    check({tag, "_p2"}, {dig3, dig2}, 8'h00);
    check({tag, "_text"}, {4'd0, text_en}, 8'b1110);
    check({tag, "_still"}, {7'd0, gra_still}, 8'd1);
    check({tag, "_winner"}, {6'd0, winner}, 8'd0);
  endtask

  initial begin
    step();
    step();
    reset = 1'b0;
    check_reset_vals("rst");

    btn_any = 1'b1;
    step();
    btn_any = 1'b0;
    check("start_state", {6'd0, game_state}, 8'd1);
    check("start_still", {7'd0, gra_still}, 8'd0);
    check("start_text", {4'd0, text_en}, 8'b1000);

    miss(1'b0, 1'b1);
    check("first_pt_p1", {dig1, dig0}, 8'h01);
    check("first_pt_p2", {dig3, dig2}, 8'h00);
    check("first_pt_state", {6'd0, game_state}, 8'd2);
    check("nb_still", {7'd0, gra_still}, 8'd1);
    check("nb_text", {4'd0, text_en}, 8'b1000);

    // Button held early: 119 ticks not enough, the 120th expires the timer.
    btn_any = 1'b1;
    ticks(119);
    step();
    check("nb_119_state", {6'd0, game_state}, 8'd2);
    ticks(1);
    check("nb_120_state", {6'd0, game_state}, 8'd2);
    step();
    check("nb_serve_state", {6'd0, game_state}, 8'd1);
    check("nb_serve_still", {7'd0, gra_still}, 8'd0);
    btn_any = 1'b0;

    // P1 from 01 up to 09.
    for (int i = 0; i < 8; i++) begin
      miss(1'b0, 1'b1);
      serve();
    end
    check("p1_09", {dig1, dig0}, 8'h09);
    miss(1'b0, 1'b1);
    check("p1_carry", {dig1, dig0}, 8'h10);
    check("p1_carry_state", {6'd0, game_state}, 8'd2);
    serve();

    // P2 from 00 up to 10.
    for (int i = 0; i < 10; i++) begin
      miss(1'b1, 1'b0);
      serve();
    end
    check("p2_10", {dig3, dig2}, 8'h10);

    miss(1'b1, 1'b1);
    check("tie_p1", {dig1, dig0}, 8'h11);
    check("tie_p2", {dig3, dig2}, 8'h11);
    check("tie_state", {6'd0, game_state}, 8'd3);
    check("tie_winner", {6'd0, winner}, 8'b11);
    check("tie_text", {4'd0, text_en}, 8'b1001);
    check("tie_still", {7'd0, gra_still}, 8'd1);

    // Misses and buttons in OVER do nothing.
    btn_any = 1'b1;
    miss(1'b1, 1'b0);
    btn_any = 1'b0;
    check("over_ignore_p2", {dig3, dig2}, 8'h11);

    ticks(119);
    step();
    check("over_119_state", {6'd0, game_state}, 8'd3);
    ticks(1);
    check("over_120_state", {6'd0, game_state}, 8'd3);
    step();
    check_reset_vals("over_end");

    // Miss in NEWGAME is ignored.
    miss(1'b1, 1'b1);
    check("ng_miss_p1", {dig1, dig0}, 8'h00);
    check("ng_miss_p2", {dig3, dig2}, 8'h00);
    check("ng_miss_state", {6'd0, game_state}, 8'd0);

    // Build 05/07 and reset mid-NEWBALL.
    btn_any = 1'b1;
    step();
    btn_any = 1'b0;
    for (int i = 0; i < 5; i++) begin
      miss(1'b0, 1'b1);
      serve();
    end
    for (int i = 0; i < 7; i++) begin
      miss(1'b1, 1'b0);
      if (i < 6) serve();
    end
    check("pre_rst_p1", {dig1, dig0}, 8'h05);
    check("pre_rst_p2", {dig3, dig2}, 8'h07);
    check("pre_rst_state", {6'd0, game_state}, 8'd2);
    ticks(5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_vals("mid_rst");

    miss(1'b1, 1'b0);
    check("post_rst_miss_p2", {dig3, dig2}, 8'h00);

    // Solo P1 win, also confirms the timer reloaded after reset.
    btn_any = 1'b1;
    step();
    btn_any = 1'b0;
    for (int i = 0; i < 10; i++) begin
      miss(1'b0, 1'b1);
      serve();
    end
    miss(1'b0, 1'b1);
    check("solo_p1", {dig1, dig0}, 8'h11);
    check("solo_state", {6'd0, game_state}, 8'd3);
    check("solo_winner", {6'd0, winner}, 8'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
